// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CPU constants and the CDB entry type
package cdb_arbiter_pkg;
  localparam int ROB_ID_W = 4;
  localparam int DATA_W = 32;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int CNT_W = $clog2(CDB_FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(CDB_FIFO_DEPTH);
  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: ALU/LSB result producers and the common data bus
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ready;
  logic                lsb_valid;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [DATA_W-1:0]   lsb_res;
  logic                lsb_ready;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_value;
  modport master(
    output alu_valid, alu_rob_id, alu_res, lsb_valid, lsb_rob_id, lsb_res,
    input  alu_ready, lsb_ready, cdb_valid, cdb_rob_id, cdb_value
  );
  modport slave(
    input  alu_valid, alu_rob_id, alu_res, lsb_valid, lsb_rob_id, lsb_res,
    output alu_ready, lsb_ready, cdb_valid, cdb_rob_id, cdb_value
  );
endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: small shift FIFO for one result producer; head is always mem[0]
module cdb_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  cdb_entry_t       din,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count
);
  cdb_entry_t mem [CDB_FIFO_DEPTH];
  logic [CNT_W-1:0] wr_idx;
  // write slot accounts for the shift of a simultaneous pop
  assign wr_idx = count - CNT_W'(pop);
  assign head = mem[0];
  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else begin
      if (pop) for (int i = 0; i < CDB_FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
      if (push) mem[wr_idx[IDX_W-1:0]] <= din;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two-source CDB arbiter; define CDB_RR_EN for round-robin, else ALU-first priority
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          clear,
  cdb_arbiter_if.slave bus
);
  logic [CNT_W-1:0] alu_cnt, lsb_cnt;
  cdb_entry_t alu_head, lsb_head;
  logic go, alu_push, lsb_push, alu_gnt, lsb_gnt;
  assign go = rdy && !clear;
  assign bus.alu_ready = alu_cnt != CNT_W'(CDB_FIFO_DEPTH);
  assign bus.lsb_ready = lsb_cnt != CNT_W'(CDB_FIFO_DEPTH);
  assign alu_push = go && bus.alu_valid && bus.alu_ready;
  assign lsb_push = go && bus.lsb_valid && bus.lsb_ready;
  cdb_fifo u_alu_fifo (
    .clk, .rst, .flush(clear), .push(alu_push), .pop(go && alu_gnt),
    .din({bus.alu_rob_id, bus.alu_res}), .head(alu_head), .count(alu_cnt)
  );
  cdb_fifo u_lsb_fifo (
    .clk, .rst, .flush(clear), .push(lsb_push), .pop(go && lsb_gnt),
    .din({bus.lsb_rob_id, bus.lsb_res}), .head(lsb_head), .count(lsb_cnt)
  );
`ifdef CDB_RR_EN
  logic last_alu;
  assign alu_gnt = alu_cnt != '0 && (lsb_cnt == '0 || !last_alu);
  assign lsb_gnt = lsb_cnt != '0 && !alu_gnt;
  always_ff @(posedge clk) begin
    if (rst || clear) last_alu <= 1'b0;
    else if (go && (alu_gnt || lsb_gnt)) last_alu <= alu_gnt;
  end
`else
  assign alu_gnt = alu_cnt != '0;
  assign lsb_gnt = lsb_cnt != '0 && !alu_gnt;
`endif
  // id/value hold their last broadcast when nothing is granted
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_rob_id <= '0;
      bus.cdb_value <= '0;
    end else if (rdy) begin
      bus.cdb_valid <= alu_gnt || lsb_gnt;
      if (alu_gnt || lsb_gnt) {bus.cdb_rob_id, bus.cdb_value} <= alu_gnt ? alu_head : lsb_head;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random checks against a queue-based model of the CDB arbiter
module tb_cdb_arbiter;
`ifdef CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, rdy, clear;
  cdb_arbiter_if bus();
  cdb_arbiter dut (.clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus.slave));
  always #5 clk = ~clk;
  int nvec = 0, nerr = 0;
  logic [35:0] qa[$], ql[$];
  logic m_valid, m_last_alu;
  logic [3:0] m_id;
  logic [31:0] m_val;

  task automatic model_edge();
    bit pa, pl, ga, gl;
    logic [35:0] e;
    pa = bus.alu_valid && qa.size() != 2;
    pl = bus.lsb_valid && ql.size() != 2;
    if (rst || clear) begin
      qa.delete(); ql.delete();
      m_valid = 0; m_id = 0; m_val = 0; m_last_alu = 0;
    end else if (rdy) begin
      ga = qa.size() > 0;
      gl = ql.size() > 0;
      if (ga && gl) begin
        if (RR) begin ga = !m_last_alu; gl = m_last_alu; end
        else gl = 0;
      end
      m_valid = ga || gl;
      e = '0;
      if (ga) begin e = qa.pop_front(); m_last_alu = 1; end
      if (gl) begin e = ql.pop_front(); m_last_alu = 0; end
      if (m_valid) {m_id, m_val} = e;
      if (pa) qa.push_back({bus.alu_rob_id, bus.alu_res});
      if (pl) ql.push_back({bus.lsb_rob_id, bus.lsb_res});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rob_id = 0; bus.alu_res = 0;
    bus.lsb_valid = 0; bus.lsb_rob_id = 0; bus.lsb_res = 0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; clear = 0; idle();
    cycle(); cycle();
    nvec++;
    if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value} !== 37'd0) begin
      nerr++; $display("FAIL reset_bus got %h want 0", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value});
    end
    rst = 0;
    cycle();
    nvec++;
    if ({bus.alu_ready, bus.lsb_ready} !== 2'b11) begin
      nerr++; $display("FAIL reset_ready got %b want 11", {bus.alu_ready, bus.lsb_ready});
    end
  endtask

  task automatic test_single();
    bus.alu_valid = 1; bus.alu_rob_id = 4'd3; bus.alu_res = 32'h1234;
    cycle();
    idle();
    cycle();
    nvec++;
    if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value} !== {1'b1, 4'd3, 32'h1234}) begin
      nerr++; $display("FAIL single_bus got %h want %h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value}, {1'b1, 4'd3, 32'h1234});
    end
    cycle();
    nvec++;
    if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value} !== {1'b0, 4'd3, 32'h1234}) begin
      nerr++; $display("FAIL single_hold got %h want %h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value}, {1'b0, 4'd3, 32'h1234});
    end
  endtask

  task automatic test_contention();
    rst = 1; cycle(); rst = 0;
    bus.alu_valid = 1; bus.alu_rob_id = 4'd1; bus.alu_res = 32'hA;
    bus.lsb_valid = 1; bus.lsb_rob_id = 4'd2; bus.lsb_res = 32'hB;
    cycle();
    idle();
    cycle();
    nvec++;
    if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value} !== {1'b1, 4'd1, 32'hA}) begin
      nerr++; $display("FAIL contention_first got %h want %h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value}, {1'b1, 4'd1, 32'hA});
    end
    cycle();
    nvec++;
    if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value} !== {1'b1, 4'd2, 32'hB}) begin
      nerr++; $display("FAIL contention_second got %h want %h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value}, {1'b1, 4'd2, 32'hB});
    end
  endtask

  task automatic test_backpressure();
    int nxt = 4;
    bit acc, drop = 0;
    logic [3:0] seen[$];
    for (int c = 0; c < 32; c++) begin
      bus.alu_valid = nxt < 8; bus.alu_rob_id = 4'(nxt); bus.alu_res = 32'(nxt * 17);
      bus.lsb_valid = c < 20; bus.lsb_rob_id = {1'b1, 3'($urandom)}; bus.lsb_res = $urandom;
      #1;
      acc = bus.alu_valid && bus.alu_ready;
      if (!bus.alu_ready) drop = 1;
      cycle();
      if (acc) nxt++;
      nvec++;
      if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready} !==
          {m_valid, m_id, m_val, qa.size() != 2, ql.size() != 2}) begin
        nerr++; $display("FAIL backpressure_cycle%0d got %h want %h", c,
          {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready},
          {m_valid, m_id, m_val, qa.size() != 2, ql.size() != 2});
      end
      if (bus.cdb_valid && bus.cdb_rob_id inside {[4:7]}) seen.push_back(bus.cdb_rob_id);
    end
    idle();
    nvec++;
    if (drop !== RR) begin
      nerr++; $display("FAIL backpressure_ready_drop got %b want %b", drop, RR);
    end
    nvec++;
    if (seen.size() != 4) begin
      nerr++; $display("FAIL backpressure_count got %0d want 4", seen.size());
    end else for (int i = 0; i < 4; i++) begin
      nvec++;
      if (seen[i] !== 4'(4 + i)) begin
        nerr++; $display("FAIL backpressure_order[%0d] got %0d want %0d", i, seen[i], 4 + i);
      end
    end
  endtask

  task automatic test_clear();
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid = 1; bus.alu_rob_id = 4'($urandom); bus.alu_res = $urandom;
      bus.lsb_valid = 1; bus.lsb_rob_id = 4'($urandom); bus.lsb_res = $urandom;
      cycle();
    end
    clear = 1;
    cycle();
    nvec++;
    if ({bus.cdb_valid, bus.alu_ready, bus.lsb_ready} !== 3'b011) begin
      nerr++; $display("FAIL clear_state got %b want 011", {bus.cdb_valid, bus.alu_ready, bus.lsb_ready});
    end
    clear = 0; idle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      nvec++;
      if (bus.cdb_valid !== 1'b0) begin
        nerr++; $display("FAIL clear_flushed_cycle%0d got %b want 0", c, bus.cdb_valid);
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 2; c++) begin
      bus.alu_valid = 1; bus.alu_rob_id = 4'(8 + c); bus.alu_res = $urandom;
      bus.lsb_valid = 1; bus.lsb_rob_id = 4'(12 + c); bus.lsb_res = $urandom;
      cycle();
    end
    rdy = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) rdy = 1;
      bus.alu_valid = 1'($urandom); bus.alu_rob_id = 4'($urandom); bus.alu_res = $urandom;
      bus.lsb_valid = 1'($urandom); bus.lsb_rob_id = 4'($urandom); bus.lsb_res = $urandom;
      if (c >= 3) idle();
      cycle();
      nvec++;
      if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready} !==
          {m_valid, m_id, m_val, qa.size() != 2, ql.size() != 2}) begin
        nerr++; $display("FAIL stall_cycle%0d got %h want %h", c,
          {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready},
          {m_valid, m_id, m_val, qa.size() != 2, ql.size() != 2});
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1; bus.alu_rob_id = 4'd9; bus.alu_res = 32'hCAFE;
    bus.lsb_valid = 1; bus.lsb_rob_id = 4'd10; bus.lsb_res = 32'hBEEF;
    cycle(); cycle();
    nvec++;
    if (bus.cdb_valid !== 1'b1) begin
      nerr++; $display("FAIL reset_mid_pre got %b want 1", bus.cdb_valid);
    end
    rst = 1;
    cycle();
    rst = 0; idle();
    nvec++;
    if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready} !== {37'd0, 2'b11}) begin
      nerr++; $display("FAIL reset_mid got %h want %h", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready}, {37'd0, 2'b11});
    end
    cycle();
    nvec++;
    if (bus.cdb_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_empty got %b want 0", bus.cdb_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = $urandom_range(0, 99) == 0;
      clear = $urandom_range(0, 49) == 0;
      rdy = $urandom_range(0, 3) != 0;
      bus.alu_valid = 1'($urandom); bus.alu_rob_id = 4'($urandom); bus.alu_res = $urandom;
      bus.lsb_valid = 1'($urandom); bus.lsb_rob_id = 4'($urandom); bus.lsb_res = $urandom;
      cycle();
      nvec++;
      if ({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready} !==
          {m_valid, m_id, m_val, qa.size() != 2, ql.size() != 2}) begin
        nerr++; $display("FAIL random_cycle%0d got %h want %h", c,
          {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.alu_ready, bus.lsb_ready},
          {m_valid, m_id, m_val, qa.size() != 2, ql.size() != 2});
      end
    end
    rst = 0; clear = 0; rdy = 1; idle();
  endtask

  initial begin
    rst = 1; rdy = 1; clear = 0; idle();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_clear();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
